// File: rtl/stream_demux_1ton.sv
// Registered 1-to-NOUT valid/ready demux: channel picked by in_sel on a packet's first beat and
// locked until in_last; one-entry output register, bad-channel packets discarded and counted.
module stream_demux_1ton #(
  parameter int WIDTH = 8,
  parameter int NOUT  = 4,
  parameter int SELW  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [SELW-1:0]       in_sel,
  input  logic                  in_last,
  output logic [NOUT-1:0]       out_valid,
  input  logic [NOUT-1:0]       out_ready,
  output logic [NOUT*WIDTH-1:0] out_data,
  output logic [NOUT-1:0]       out_last,
  output logic [7:0]            drop_cnt,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;

  state_t           state;
  logic [SELW-1:0]  lock_ch;
  logic [SELW-1:0]  hold_ch;
  logic [WIDTH-1:0] hold_data;
  logic             hold_last;
  logic             hold_full;

  logic [NOUT-1:0]  ch_hit;
  logic [SELW-1:0]  dest;
  logic             sel_bad;
  logic             dropping;
  logic             drain;
  logic             accept;

  always_comb begin
    ch_hit = '0;
    for (int k = 0; k < NOUT; k++) begin
      ch_hit[k] = (hold_ch == SELW'(k));
    end
  end

  assign out_valid = hold_full ? ch_hit : '0;
  assign out_last  = (hold_full && hold_last) ? ch_hit : '0;

  // Non-addressed slices are forced to zero so only the live channel carries data.
  always_comb begin
    out_data = '0;
    for (int k = 0; k < NOUT; k++) begin
      out_data[k*WIDTH +: WIDTH] = out_valid[k] ? hold_data : '0;
    end
  end

  assign drain    = |(out_valid & out_ready);
  assign sel_bad  = (state == IDLE) && ({1'b0, in_sel} >= (SELW+1)'(NOUT));
  assign dropping = (state == DROP) || sel_bad;
  assign dest     = (state == IDLE) ? in_sel : lock_ch;
  assign in_ready = !rst && (dropping || !hold_full || drain);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE) || hold_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lock_ch   <= '0;
      hold_ch   <= '0;
      hold_data <= '0;
      hold_last <= 1'b0;
      hold_full <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      // A drain and a routed accept in the same cycle simply reload the register.
      if (accept && !dropping) begin
        hold_data <= in_data;
        hold_ch   <= dest;
        hold_last <= in_last;
        hold_full <= 1'b1;
      end else if (drain) begin
        hold_full <= 1'b0;
      end

      if (accept) begin
        case (state)
          IDLE: begin
            if (sel_bad) begin
              if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
              if (!in_last) state <= DROP;
            end else begin
              lock_ch <= in_sel;
              if (!in_last) state <= ROUTE;
            end
          end
          ROUTE, DROP: begin
            if (in_last) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_stream_demux_1ton.sv
// Bench for stream_demux_1ton: a 4-channel and a 3-channel instance, directed scenarios plus
// random packets, checked each cycle against a packet-level model.
module tb_stream_demux_1ton;
  logic clk;
  logic rst;

  // index 0: NOUT=4 instance, index 1: NOUT=3 instance
  logic       in_valid  [2];
  logic [7:0] in_data   [2];
  logic [1:0] in_sel    [2];
  logic       in_last   [2];
  logic [3:0] out_ready [2];

  wire        in_ready  [2];
  wire [3:0]  out_valid [2];
  wire [3:0]  out_last  [2];
  wire [31:0] out_data  [2];
  wire [7:0]  drop_cnt  [2];
  wire        busy      [2];

  wire [2:0]  ov3, ol3;
  wire [23:0] od3;

  stream_demux_1ton #(.WIDTH(8), .NOUT(4), .SELW(2)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .in_sel(in_sel[0]), .in_last(in_last[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .out_last(out_last[0]), .drop_cnt(drop_cnt[0]), .busy(busy[0])
  );

  stream_demux_1ton #(.WIDTH(8), .NOUT(3), .SELW(2)) dut3 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .in_sel(in_sel[1]), .in_last(in_last[1]),
    .out_valid(ov3), .out_ready(out_ready[1][2:0]), .out_data(od3),
    .out_last(ol3), .drop_cnt(drop_cnt[1]), .busy(busy[1])
  );

  assign out_valid[1] = {1'b0, ov3};
  assign out_last[1]  = {1'b0, ol3};
  assign out_data[1]  = {8'h00, od3};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %h, expected %h (cycle %0d)", name, d, act, exp, cyc);
    end
  endtask

  function automatic int nout(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  // Model: packet mode (0 between packets, 1 routing, 2 discarding) plus the beat currently
  // owed to an output; at most one beat can be outstanding.
  int         mode [2];
  int         lock [2];
  bit         pv   [2];
  int         pch  [2];
  logic [7:0] pdat [2];
  bit         plast[2];
  int         cnt  [2];

  bit         s_rst = 1'b1;
  bit         s_v   [2];
  bit         s_rdy [2];
  bit         s_drain[2];
  logic [7:0] s_dat [2];
  int         s_sel [2];
  bit         s_last[2];

  function automatic bit model_rdy(input int d);
    bit bad;
    if (rst) return 1'b0;
    bad = (mode[d] == 0) && (int'(in_sel[d]) >= nout(d));
    return (mode[d] == 2) || bad || !pv[d] || out_ready[d][pch[d]];
  endfunction

  typedef struct {
    int         d;
    int         ch;
    logic [7:0] dat;
    logic       last;
    int         cyc;
  } obs_t;
  obs_t obs[$];

  logic [31:0] ev, ed, el;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      ev = pv[d] ? (32'd1 << pch[d]) : 32'd0;
      el = (pv[d] && plast[d]) ? ev : 32'd0;
      ed = pv[d] ? (32'(pdat[d]) << (8 * pch[d])) : 32'd0;
      chk("in_ready", d, 32'(in_ready[d]), 32'(model_rdy(d)));
      chk("out_valid", d, 32'(out_valid[d]), ev);
      chk("out_last", d, 32'(out_last[d]), el);
      chk("out_data", d, out_data[d], ed);
      chk("drop_cnt", d, 32'(drop_cnt[d]), 32'(cnt[d]));
      chk("busy", d, 32'(busy[d]), 32'((mode[d] != 0) || pv[d]));
      for (int ch = 0; ch < nout(d); ch++) begin
        if (out_valid[d][ch] && out_ready[d][ch])
          obs.push_back('{d, ch, out_data[d][8*ch +: 8], out_last[d][ch], cyc});
      end
      s_v[d]     = in_valid[d];
      s_rdy[d]   = model_rdy(d);
      s_drain[d] = pv[d] && out_ready[d][pch[d]];
      s_dat[d]   = in_data[d];
      s_sel[d]   = int'(in_sel[d]);
      s_last[d]  = in_last[d];
    end
    s_rst = rst;
  end

  always @(posedge clk) begin
    bit bad;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (s_rst) begin
        mode[d] = 0; pv[d] = 1'b0; cnt[d] = 0;
      end else begin
        if (s_drain[d]) pv[d] = 1'b0;
        if (s_v[d] && s_rdy[d]) begin
          bad = (mode[d] == 0) && (s_sel[d] >= nout(d));
          if (mode[d] == 2 || bad) begin
            if (bad && cnt[d] < 255) cnt[d]++;
            mode[d] = s_last[d] ? 0 : 2;
          end else begin
            if (mode[d] == 0) lock[d] = s_sel[d];
            pv[d] = 1'b1; pch[d] = lock[d]; pdat[d] = s_dat[d]; plast[d] = s_last[d];
            mode[d] = s_last[d] ? 0 : 1;
          end
        end
      end
    end
  end

  bit rand_ordy[2];
  always @(posedge clk) begin
    #2;
    for (int d = 0; d < 2; d++) if (rand_ordy[d]) out_ready[d] = 4'($urandom);
  end

  task automatic send(input int d, input logic [7:0] dat, input logic [1:0] sel, input bit last,
                      output int waits);
    waits = 0;
    in_valid[d] = 1'b1; in_data[d] = dat; in_sel[d] = sel; in_last[d] = last;
    do begin
      @(negedge clk);
      waits++;
    end while (!in_ready[d] && waits < 200);
    if (!in_ready[d]) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout dut%0d: in_ready still 0, expected 1 within 200 cycles", d);
    end
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic run_random(input int d);
    int len, w;
    logic [1:0] sel;
    rand_ordy[d] = 1'b1;
    for (int p = 0; p < 120; p++) begin
      len = $urandom_range(1, 4);
      sel = 2'($urandom_range(0, 3));
      for (int b = 0; b < len; b++) begin
        send(d, 8'($urandom), (b == 0) ? sel : 2'($urandom), b == len - 1, w);
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      end
    end
    rand_ordy[d] = 1'b0;
    #1 out_ready[d] = 4'hF;
  endtask

  int exp_ch [4] = '{1, 1, 1, 3};
  int exp_dat[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  int exp_lst[4] = '{0, 0, 1, 1};

  initial begin
    int w;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b1; in_data[d] = 8'hFF; in_sel[d] = 2'(d); in_last[d] = 1'b0;
      out_ready[d] = 4'hF;
    end

    // Reset with a valid beat pending on both inputs
    repeat (2) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk("rst_in_ready", d, 32'(in_ready[d]), 32'd0);
        chk("rst_out_valid", d, 32'(out_valid[d]), 32'd0);
        chk("rst_drop_cnt", d, 32'(drop_cnt[d]), 32'd0);
        chk("rst_busy", d, 32'(busy[d]), 32'd0);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) in_valid[d] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("post_rst_out_valid", d, 32'(out_valid[d]), 32'd0);
      chk("post_rst_out_data", d, out_data[d], 32'd0);
      chk("post_rst_busy", d, 32'(busy[d]), 32'd0);
    end
    @(posedge clk); #1;

    // Single-beat packet to channel 2
    send(0, 8'hA5, 2'd2, 1'b1, w);
    @(negedge clk);
    chk("single_out_valid", 0, 32'(out_valid[0]), 32'h4);
    chk("single_out_last", 0, 32'(out_last[0]), 32'h4);
    chk("single_out_data", 0, out_data[0], 32'h00A5_0000);
    @(negedge clk);
    chk("single_after_valid", 0, 32'(out_valid[0]), 32'h0);
    @(posedge clk); #1;

    // Channel locked for the whole packet regardless of later in_sel
    obs.delete();
    send(0, 8'h11, 2'd1, 1'b0, w);
    send(0, 8'h22, 2'd3, 1'b0, w);
    send(0, 8'h33, 2'd3, 1'b1, w);
    send(0, 8'h44, 2'd3, 1'b1, w);
    repeat (3) @(negedge clk);
    chk("lock_count", 0, 32'(obs.size()), 32'd4);
    for (int i = 0; i < obs.size() && i < 4; i++) begin
      chk("lock_ch", 0, 32'(obs[i].ch), 32'(exp_ch[i]));
      chk("lock_data", 0, 32'(obs[i].dat), 32'(exp_dat[i]));
      chk("lock_last", 0, 32'(obs[i].last), 32'(exp_lst[i]));
    end
    @(posedge clk); #1;

    // Backpressure on channel 0, then release
    obs.delete();
    out_ready[0] = 4'b1110;
    fork
      begin
        for (int i = 1; i <= 4; i++) send(0, 8'(i), 2'd0, i == 4, w);
      end
      begin
        repeat (2) @(negedge clk);
        chk("bp_in_ready_held", 0, 32'(in_ready[0]), 32'd0);
        chk("bp_held_valid", 0, 32'(out_valid[0]), 32'h1);
        chk("bp_held_data", 0, out_data[0], 32'h1);
        repeat (4) @(posedge clk);
        #1 out_ready[0] = 4'hF;
      end
    join
    repeat (3) @(negedge clk);
    chk("bp_count", 0, 32'(obs.size()), 32'd4);
    for (int i = 0; i < obs.size() && i < 4; i++) begin
      chk("bp_order", 0, 32'(obs[i].dat), 32'(i + 1));
      if (i > 0) chk("bp_consecutive", 0, 32'(obs[i].cyc - obs[i-1].cyc), 32'd1);
    end
    @(posedge clk); #1;

    // Reset while routing with a full holding register
    out_ready[0] = 4'b1011;
    send(0, 8'h5A, 2'd2, 1'b0, w);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 0, 32'(out_valid[0]), 32'd0);
    chk("midrst_busy", 0, 32'(busy[0]), 32'd0);
    @(posedge clk); #1;
    out_ready[0] = 4'hF;
    obs.delete();
    send(0, 8'hC3, 2'd0, 1'b1, w);
    repeat (2) @(negedge clk);
    chk("midrst_count", 0, 32'(obs.size()), 32'd1);
    if (obs.size() > 0) begin
      chk("midrst_ch", 0, 32'(obs[0].ch), 32'd0);
      chk("midrst_data", 0, 32'(obs[0].dat), 32'hC3);
    end
    @(posedge clk); #1;

    // Invalid select on the 3-channel instance
    obs.delete();
    for (int b = 0; b < 4; b++) begin
      send(1, 8'(8'h60 + b), 2'd3, b == 3, w);
      chk("drop_accept_wait", 1, 32'(w), 32'd1);
    end
    @(negedge clk);
    chk("drop_cnt_one", 1, 32'(drop_cnt[1]), 32'd1);
    chk("drop_no_output", 1, 32'(obs.size()), 32'd0);
    @(posedge clk); #1;

    fork
      run_random(0);
      run_random(1);
    join
    repeat (4) @(posedge clk);
    #1;

    // Saturation of the drop counter
    for (int i = 0; i < 300; i++) send(1, 8'(i), 2'd3, 1'b1, w);
    @(negedge clk);
    chk("drop_cnt_sat", 1, 32'(drop_cnt[1]), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", miscompares);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/stream_demux_1ton.md
Name: stream_demux_1toN

Overview:
- Registered, parametrised 1-to-N demultiplexer for valid/ready streams. Successor to the combinational 1-to-4 demux.
- Routes each packet of WIDTH-bit beats from one input stream to one of NOUT output streams.
- Output channel is chosen by in_sel on the first beat and locked for the rest of the packet.
- Has a one-entry output register with full backpressure, discard of packets addressed to a non-existent channel, and a saturating drop counter.

Parameters:
- WIDTH, 8, data beat width in bits (>=1).
- NOUT, 4, number of output channels (2..2**SELW).
- SELW, 2, select field width in bits (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept the input beat.
- in_data  input  WIDTH  input beat data.
- in_sel  input  SELW  destination channel; sampled on the first beat of a packet only.
- in_last  input  1  marks the final beat of a packet.
- out_valid  output  NOUT  per-channel valid; bit k belongs to channel k.
- out_ready  input  NOUT  per-channel ready.
- out_data  output  NOUT*WIDTH  channel k data on bits [k*WIDTH +: WIDTH].
- out_last  output  NOUT  per-channel last.
- drop_cnt  output  8  count of discarded packets, saturating.
- busy  output  1  high when state != IDLE or the holding register is full.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values while rst is high and in the cycle after it deasserts:
  - state = IDLE, hold_full = 0.
  - out_valid = 0, out_last = 0, out_data = 0, drop_cnt = 0, busy = 0.
  - in_ready is forced to 0 while rst is high.
- Transfers:
  - Input transfer: in_valid & in_ready at a rising edge.
  - Output transfer on channel k: out_valid[k] & out_ready[k].
  - The source holds in_valid and its payload stable until the beat is accepted.
- Holding register: hold_data, hold_ch, hold_last, hold_full.
  - out_valid[k] = hold_full & (hold_ch == k).
  - out_last[k] follows the same rule using hold_last.
  - The out_data slice for the addressed channel carries hold_data; all other slices are 0 (AND-gated, as in the combinational demux).
  - Only one out_valid bit is ever high.
- Accept rule for a routed beat: in_ready = ~hold_full | out_ready[hold_ch]. This allows a pass-through reload in the same cycle.
- Latency and throughput:
  - An accepted routed beat appears on its output exactly 1 cycle after acceptance.
  - Sustained throughput is 1 beat/clk when the destination is ready.
- Simultaneous output drain and input accept: the register reloads with the new beat and hold_full stays 1. Beat order is preserved.
- Drain without accept: hold_full clears at the edge.
- State machine:
  - IDLE:
    - Valid beat with in_sel < NOUT: the beat is routed to in_sel and lock_ch <= in_sel. If in_last = 0, go to ROUTE; if in_last = 1, stay in IDLE (single-beat packet).
    - Valid beat with in_sel >= NOUT: in_ready = 1 regardless of the holding register, and the beat is discarded. drop_cnt increments by 1 (saturates at 255). If in_last = 0, go to DROP.
  - ROUTE: in_sel is ignored. Beats route to lock_ch. An accepted beat with in_last = 1 returns the FSM to IDLE.
  - DROP: in_ready = 1. Beats are discarded with no output activity and no further drop_cnt increment. A beat with in_last = 1 returns the FSM to IDLE.
- Channel change across packets: a packet to a different channel may be accepted while the holding register still holds the previous packet's last beat, subject to the accept rule for routed beats.
- Reset mid-packet: the packet is abandoned, the holding contents are lost, and the next accepted beat is treated as a first beat.
- When NOUT == 2**SELW, an invalid select cannot occur and DROP is unreachable.

Test Plan:
- Reset: hold rst for 2 clk with in_valid = 1 -> in_ready = 0, out_valid = 0, drop_cnt = 0, busy = 0 throughout, and in the cycle after rst falls.
- Single-beat route (NOUT=4): in_data = 0xA5, in_sel = 2, in_last = 1, out_ready = 4'b1111 -> one cycle after acceptance:
  - out_valid = 4'b0100, out_last = 4'b0100.
  - Slice 2 = 0xA5, other slices = 0x00.
  - Next cycle out_valid = 0.
- Packet lock: 3-beat packet 0x11/0x22/0x33 with in_sel = 1 on the first beat and in_sel = 3 on beats 2–3 -> all three beats appear on channel 1 and out_last[1] is set only on 0x33. The following packet with in_sel = 3 appears on channel 3.
- Backpressure: continuous stream 1,2,3,4 to channel 0 with out_ready[0] = 0 for 5 cycles ->
  - Beat 1 is held and in_ready = 0 after the first accept.
  - On release, beats 1–4 emerge on consecutive cycles in order, with no loss or duplication.
- Invalid select (NOUT=3, SELW=2): 4-beat packet with in_sel = 3 -> in_ready = 1 on all beats, out_valid stays 0, drop_cnt = 1. After 300 single-beat invalid packets, drop_cnt = 255.
- Reset mid-packet: in ROUTE to channel 2 with hold_full = 1, assert rst for 1 clk -> out_valid = 0. The next beat with in_sel = 0 and in_last = 1 appears on channel 0.
